int_ctrl_nested: RTL and testbench



---
 rtl/int_ctrl_nested.sv | 119 +++++++++++
 tb/tb_int_ctrl_nested.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl_nested.sv
// Nested interrupt controller: rising-edge request latching, fixed priority with
// per-source masking, strict-priority preemption and a {id, return PC} context stack.
module int_ctrl_nested #(
  parameter int                NUM_IRQ    = 4,
  parameter int                NEST_DEPTH = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h0009),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h00C0),
  localparam int               ID_W       = $clog2(NUM_IRQ + 1),
  localparam int               LVL_W      = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               CLR,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               eret,
  input  logic [ADDR_W-1:0]  epc_in,
  output logic               Int,
  output logic [ADDR_W-1:0]  Iaddr,
  output logic [ADDR_W-1:0]  EPC,
  output logic [ID_W-1:0]    cur_ir,
  output logic [LVL_W-1:0]   nest_level,
  output logic [NUM_IRQ-1:0] pending,
  output logic               ie
);

  localparam int PTR_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [ID_W-1:0]    stk_id [NEST_DEPTH];
  logic [ADDR_W-1:0]  stk_pc [NEST_DEPTH];

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr_bits;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_idx;
  logic [ID_W-1:0]    cand_id;
  logic               accept;
  logic               pop;
  logic [PTR_W-1:0]   push_ptr;
  logic [PTR_W-1:0]   top_ptr;
  logic [PTR_W-1:0]   below_ptr;
  logic [ADDR_W-1:0]  vec;

  assign ie = (nest_level == '0);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    rise       = irq & ~irq_d;
    eligible   = pending & ~mask_q;
    cand_valid = 1'b0;
    cand_idx   = '0;
    // Scan from lowest priority upward so the last hit is the highest priority.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        cand_valid = 1'b1;
        cand_idx   = ID_W'(i);
      end
    end
    cand_id = cand_idx + ID_W'(1);

    // Equal priority never preempts; eret and a just-issued Int both stall acceptance.
    accept = cand_valid
          && ((cur_ir == '0) || (cand_id < cur_ir))
          && (nest_level < LVL_W'(NEST_DEPTH))
          && !eret
          && !Int;
    pop    = eret && (nest_level != '0);

    clr_bits  = accept ? (NUM_IRQ'(1) << cand_idx) : '0;
    push_ptr  = PTR_W'(nest_level);
    top_ptr   = PTR_W'(nest_level - LVL_W'(1));
    below_ptr = PTR_W'(nest_level - LVL_W'(2));
    vec       = VEC_BASE + ADDR_W'(cand_idx) * VEC_STRIDE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (CLR) begin
      irq_d      <= '0;
      mask_q     <= '0;
      pending    <= '0;
      Int        <= 1'b0;
      Iaddr      <= '0;
      EPC        <= '0;
      cur_ir     <= '0;
      nest_level <= '0;
      // NOTE: the context stack is reset explicitly so a mid-handler CLR leaves
      // no stale {id, PC} entries behind; it is small enough to live in flops.
      for (int j = 0; j < NEST_DEPTH; j++) begin
        stk_id[j] <= '0;
        stk_pc[j] <= '0;
      end
    end else begin
      irq_d   <= irq;
      mask_q  <= irq_mask;
      // A new rise wins over the acceptance clear of the same bit.
      pending <= (pending & ~clr_bits) | rise;
      Int     <= accept;
      if (accept) begin
        stk_id[push_ptr] <= cur_ir;
        stk_pc[push_ptr] <= epc_in;
        cur_ir           <= cand_id;
        nest_level       <= nest_level + LVL_W'(1);
        EPC              <= epc_in;
        Iaddr            <= vec;
      end else if (pop) begin
        cur_ir     <= stk_id[top_ptr];
        nest_level <= nest_level - LVL_W'(1);
        EPC        <= (nest_level > LVL_W'(1)) ? stk_pc[below_ptr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl_nested.sv
// Directed bench for int_ctrl_nested (NUM_IRQ=4, NEST_DEPTH=2); every Int pulse
// is matched against a scoreboard of expected {vector, id, EPC, level}.
module tb_int_ctrl_nested;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] id;
    logic [31:0] epc;
    logic [31:0] lvl;
  } exp_t;

  logic        clk = 1'b0;
  logic        CLR;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        eret;
  logic [31:0] epc_in;
  logic        Int;
  logic [31:0] Iaddr;
  logic [31:0] EPC;
  logic [2:0]  cur_ir;
  logic [1:0]  nest_level;
  logic [3:0]  pending;
  logic        ie;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  int_ctrl_nested #(.NUM_IRQ(4), .NEST_DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .CLR(CLR), .irq(irq), .irq_mask(irq_mask), .eret(eret),
    .epc_in(epc_in), .Int(Int), .Iaddr(Iaddr), .EPC(EPC), .cur_ir(cur_ir),
    .nest_level(nest_level), .pending(pending), .ie(ie)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_int(input logic [31:0] addr, input logic [31:0] id,
                            input logic [31:0] epc, input logic [31:0] lvl);
    exp_t e;
    e.addr = addr; e.id = id; e.epc = epc; e.lvl = lvl;
    sb.push_back(e);
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    cyc(1);
    eret = 1'b0;
  endtask

  // Scoreboard consumer: each Int pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (Int === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_int", 32'(Int), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_iaddr", Iaddr, e.addr);
        check("sb_cur_ir", 32'(cur_ir), e.id);
        check("sb_epc", EPC, e.epc);
        check("sb_nest", 32'(nest_level), e.lvl);
      end
    end
  end

  initial begin
    CLR = 1'b1; irq = '0; irq_mask = '0; eret = 1'b0; epc_in = '0;
    cyc(2);
    check("rst_int", 32'(Int), 32'd0);
    check("rst_iaddr", Iaddr, 32'd0);
    check("rst_epc", EPC, 32'd0);
    check("rst_cur_ir", 32'(cur_ir), 32'd0);
    check("rst_nest", 32'(nest_level), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ie", 32'(ie), 32'd1);
    CLR = 1'b0;
    cyc(1);

    // 1: single request, latency and return
    irq = 4'b0100; epc_in = 32'h1000;
    expect_int(32'h189, 3, 32'h1000, 1);
    cyc(1);
    check("t1_int_early", 32'(Int), 32'd0);
    check("t1_pending", 32'(pending), 32'b0100);
    cyc(1);
    check("t1_int", 32'(Int), 32'd1);
    check("t1_ie", 32'(ie), 32'd0);
    cyc(1);
    check("t1_int_one_cycle", 32'(Int), 32'd0);
    pulse_eret();
    check("t1_ret_cur_ir", 32'(cur_ir), 32'd0);
    check("t1_ret_nest", 32'(nest_level), 32'd0);
    check("t1_ret_ie", 32'(ie), 32'd1);
    check("t1_ret_epc", EPC, 32'd0);

    // 2: preemption by a higher-priority source
    irq = 4'b0000; cyc(1);
    irq = 4'b0100; epc_in = 32'h2000;
    expect_int(32'h189, 3, 32'h2000, 1);
    cyc(2);
    check("t2_int_a", 32'(Int), 32'd1);
    irq = 4'b0101; epc_in = 32'h3000;
    expect_int(32'h009, 1, 32'h3000, 2);
    cyc(2);
    check("t2_int_b", 32'(Int), 32'd1);
    check("t2_nest", 32'(nest_level), 32'd2);
    pulse_eret();
    check("t2_ret1_cur_ir", 32'(cur_ir), 32'd3);
    check("t2_ret1_epc", EPC, 32'h2000);
    check("t2_ret1_nest", 32'(nest_level), 32'd1);
    pulse_eret();
    check("t2_ret2_cur_ir", 32'(cur_ir), 32'd0);
    check("t2_ret2_epc", EPC, 32'd0);

    // 3 + 5a: lower priority waits; eret and candidate collide, eret wins
    irq = 4'b0000; cyc(1);
    irq = 4'b0001; epc_in = 32'h4000;
    expect_int(32'h009, 1, 32'h4000, 1);
    cyc(2);
    irq = 4'b1001;
    cyc(2);
    check("t3_no_int", 32'(Int), 32'd0);
    check("t3_pending", 32'(pending), 32'b1000);
    check("t3_cur_ir", 32'(cur_ir), 32'd1);
    epc_in = 32'h5000;
    expect_int(32'h249, 4, 32'h5000, 1);
    pulse_eret();
    check("t5_eret_wins_int", 32'(Int), 32'd0);
    check("t5_eret_wins_cur_ir", 32'(cur_ir), 32'd0);
    cyc(1);
    check("t3_int_after_eret", 32'(Int), 32'd1);
    pulse_eret();
    check("t3_ret_cur_ir", 32'(cur_ir), 32'd0);

    // 4: stack full holds the third request until an eret
    irq = 4'b0000; cyc(1);
    irq = 4'b1000; epc_in = 32'h6000;
    expect_int(32'h249, 4, 32'h6000, 1);
    cyc(2);
    irq = 4'b1100; epc_in = 32'h7000;
    expect_int(32'h189, 3, 32'h7000, 2);
    cyc(2);
    check("t4_int_b", 32'(Int), 32'd1);
    irq = 4'b1110; epc_in = 32'h8000;
    cyc(3);
    check("t4_full_no_int", 32'(Int), 32'd0);
    check("t4_full_pending", 32'(pending), 32'b0010);
    check("t4_full_nest", 32'(nest_level), 32'd2);
    check("t4_full_cur_ir", 32'(cur_ir), 32'd3);
    expect_int(32'h0C9, 2, 32'h8000, 2);
    pulse_eret();
    check("t4_ret_nest", 32'(nest_level), 32'd1);
    check("t4_ret_cur_ir", 32'(cur_ir), 32'd4);
    check("t4_ret_epc", EPC, 32'h6000);
    cyc(1);
    check("t4_int_c", 32'(Int), 32'd1);
    pulse_eret();
    check("t4_ret2_cur_ir", 32'(cur_ir), 32'd4);
    check("t4_ret2_epc", EPC, 32'h6000);
    pulse_eret();
    check("t4_ret3_cur_ir", 32'(cur_ir), 32'd0);

    // 5b: eret with nothing active changes nothing
    irq = 4'b0000; cyc(1);
    pulse_eret();
    check("t5_idle_cur_ir", 32'(cur_ir), 32'd0);
    check("t5_idle_nest", 32'(nest_level), 32'd0);
    check("t5_idle_epc", EPC, 32'd0);
    check("t5_idle_iaddr", Iaddr, 32'h0C9);
    check("t5_idle_ie", 32'(ie), 32'd1);

    // Re-rise of the active source: re-pended, serviced only after its eret
    irq = 4'b0100; epc_in = 32'hA000;
    expect_int(32'h189, 3, 32'hA000, 1);
    cyc(2);
    irq = 4'b0000; cyc(1);
    irq = 4'b0100; cyc(2);
    check("rr_no_int", 32'(Int), 32'd0);
    check("rr_pending", 32'(pending), 32'b0100);
    epc_in = 32'hB000;
    expect_int(32'h189, 3, 32'hB000, 1);
    pulse_eret();
    check("rr_ret_cur_ir", 32'(cur_ir), 32'd0);
    cyc(1);
    check("rr_int", 32'(Int), 32'd1);
    pulse_eret();
    irq = 4'b0000; cyc(1);

    // 6: masking holds, unmask issues Int two cycles later, CLR mid-handler
    irq_mask = 4'b0010; irq = 4'b0010;
    cyc(3);
    check("t6_masked_pending", 32'(pending), 32'b0010);
    check("t6_masked_no_int", 32'(Int), 32'd0);
    irq_mask = 4'b0000; epc_in = 32'h9000;
    expect_int(32'h0C9, 2, 32'h9000, 1);
    cyc(1);
    check("t6_unmask_early", 32'(Int), 32'd0);
    cyc(1);
    check("t6_unmask_int", 32'(Int), 32'd1);
    irq = 4'b0000; CLR = 1'b1;
    cyc(1);
    check("t6_clr_int", 32'(Int), 32'd0);
    check("t6_clr_iaddr", Iaddr, 32'd0);
    check("t6_clr_epc", EPC, 32'd0);
    check("t6_clr_cur_ir", 32'(cur_ir), 32'd0);
    check("t6_clr_nest", 32'(nest_level), 32'd0);
    check("t6_clr_pending", 32'(pending), 32'd0);
    check("t6_clr_ie", 32'(ie), 32'd1);
    CLR = 1'b0;
    cyc(3);
    check("t6_post_clr_int", 32'(Int), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
